// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - pipeline execute stage with ALU, branch resolve and 32-cycle MULTU/DIVU unit
//
// Purpose: computes the EX result of one instruction per cycle and registers it
// into the EX/MEM outputs. MULTU/DIVU run on an iterative unit that writes the
// internal HI/LO registers and holds the pipeline with stall while it works.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   PC                        PC+4 of the instruction in EX
//   Rt, Rd                    register specifiers
//   imm16                     immediate field
//   busA, busB                operand values
//   ExtOp, ALUSrc, RegDst,    decoded controls
//   R_type, MemWr, Branch,
//   MemtoReg, RegWr
//   ALUop                     I-type ALU operation
//   func                      R-type function field
//   stall                     combinational; upstream holds inputs while high
//   alu_result, store_data,   registered EX/MEM data
//   branch_target
//   dest_reg                  registered write specifier
//   MemWr_out, MemtoReg_out,  registered controls
//   RegWr_out, branch_taken
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  input  logic [4:0]  Rt,
  input  logic [4:0]  Rd,
  input  logic [15:0] imm16,
  input  logic [31:0] busA,
  input  logic [31:0] busB,
  input  logic        ExtOp,
  input  logic        ALUSrc,
  input  logic        RegDst,
  input  logic        R_type,
  input  logic        MemWr,
  input  logic        Branch,
  input  logic        MemtoReg,
  input  logic        RegWr,
  input  logic [2:0]  ALUop,
  input  logic [5:0]  func,
  output logic        stall,
  output logic [31:0] alu_result,
  output logic [31:0] store_data,
  output logic [31:0] branch_target,
  output logic [4:0]  dest_reg,
  output logic        MemWr_out,
  output logic        MemtoReg_out,
  output logic        RegWr_out,
  output logic        branch_taken
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  md_state_e   state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  // acc: product high half (MULTU) or partial remainder (DIVU)
  // sh : multiplier being consumed (MULTU) or dividend/quotient (DIVU)
  // opd: multiplicand (MULTU) or divisor (DIVU)
  logic [31:0] acc_q, acc_d, sh_q, sh_d, opd_q, opd_d;
  logic        div_q, div_d;

  logic [31:0] alu_result_q, store_data_q, branch_target_q;
  logic [4:0]  dest_reg_q;
  logic        mem_wr_q, mem_to_reg_q, reg_wr_q, branch_taken_q;

  logic [31:0] imm32, op_b, result;
  logic        is_multu, is_divu, md_op, start, last;

  assign imm32    = ExtOp ? {{16{imm16[15]}}, imm16} : {16'h0000, imm16};
  assign op_b     = ALUSrc ? imm32 : busB;
  assign is_multu = R_type & (func == 6'b011001);
  assign is_divu  = R_type & (func == 6'b011011);
  assign md_op    = is_multu | is_divu;
  assign start    = md_op & (state_q == IDLE);
  assign last     = (state_q == BUSY) & (cnt_q == 5'd31);
  assign stall    = start | ((state_q == BUSY) & ~last);

  always_comb begin
    result = 32'h0;
    if (!R_type) begin
      case (ALUop)
        3'b000: result = busA + op_b;
        3'b001: result = busA - op_b;
        3'b010: result = busA & op_b;
        3'b011: result = busA | op_b;
        3'b100: result = {31'h0, $signed(busA) < $signed(op_b)};
        3'b101: result = {31'h0, busA < op_b};
        3'b110: result = {imm16, 16'h0000};
        default: result = busA ^ op_b;
      endcase
    end else begin
      case (func)
        6'b100000: result = busA + op_b;
        6'b100010: result = busA - op_b;
        6'b100100: result = busA & op_b;
        6'b100101: result = busA | op_b;
        6'b100110: result = busA ^ op_b;
        6'b101010: result = {31'h0, $signed(busA) < $signed(op_b)};
        6'b101011: result = {31'h0, busA < op_b};
        6'b010000: result = hi_q;
        6'b010010: result = lo_q;
        default:   result = 32'h0;
      endcase
    end
  end

  // One shift-add multiply step: add multiplicand when the multiplier LSB is
  // set, then shift the 65-bit {carry, acc, sh} right by one.
  logic [32:0] mul_sum;
  logic [31:0] mul_acc, mul_sh;
  assign mul_sum = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opd_q} : 33'h0);
  assign mul_acc = mul_sum[32:1];
  assign mul_sh  = {mul_sum[0], sh_q[31:1]};

  // One restoring divide step. With a zero divisor every step "succeeds",
  // which naturally yields quotient all-ones and remainder = dividend.
  logic [32:0] rem_sh;
  logic [31:0] div_diff, div_acc, div_sh;
  logic        div_ge;
  assign rem_sh   = {acc_q, sh_q[31]};
  assign div_ge   = rem_sh >= {1'b0, opd_q};
  assign div_diff = rem_sh[31:0] - opd_q;
  assign div_acc  = div_ge ? div_diff : rem_sh[31:0];
  assign div_sh   = {sh_q[30:0], div_ge};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    opd_d   = opd_q;
    div_d   = div_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BUSY;
          cnt_d   = 5'd0;
          acc_d   = 32'h0;
          div_d   = is_divu;
          sh_d    = is_divu ? busA : busB;
          opd_d   = is_divu ? busB : busA;
        end
      end
      default: begin
        acc_d = div_q ? div_acc : mul_acc;
        sh_d  = div_q ? div_sh  : mul_sh;
        cnt_d = cnt_q + 5'd1;
        if (last) begin
          hi_d    = acc_d;
          lo_d    = sh_d;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      acc_q   <= 32'h0;
      sh_q    <= 32'h0;
      opd_q   <= 32'h0;
      div_q   <= 1'b0;
      hi_q    <= 32'h0;
      lo_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      opd_q   <= opd_d;
      div_q   <= div_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_result_q    <= 32'h0;
      store_data_q    <= 32'h0;
      branch_target_q <= 32'h0;
      dest_reg_q      <= 5'd0;
      mem_wr_q        <= 1'b0;
      mem_to_reg_q    <= 1'b0;
      reg_wr_q        <= 1'b0;
      branch_taken_q  <= 1'b0;
    end else begin
      alu_result_q    <= result;
      store_data_q    <= busB;
      branch_target_q <= PC + {{14{imm16[15]}}, imm16, 2'b00};
      dest_reg_q      <= RegDst ? Rd : Rt;
      // Stalled cycles and MULTU/DIVU themselves leave as bubbles.
      if (stall | md_op) begin
        mem_wr_q       <= 1'b0;
        mem_to_reg_q   <= 1'b0;
        reg_wr_q       <= 1'b0;
        branch_taken_q <= 1'b0;
      end else begin
        mem_wr_q       <= MemWr;
        mem_to_reg_q   <= MemtoReg;
        reg_wr_q       <= RegWr;
        branch_taken_q <= Branch & (busA == busB);
      end
    end
  end

  assign alu_result    = alu_result_q;
  assign store_data    = store_data_q;
  assign branch_target = branch_target_q;
  assign dest_reg      = dest_reg_q;
  assign MemWr_out     = mem_wr_q;
  assign MemtoReg_out  = mem_to_reg_q;
  assign RegWr_out     = reg_wr_q;
  assign branch_taken  = branch_taken_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - randomized self-checking bench for ex_stage against an arithmetic reference model
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC;
  logic [4:0]  Rt, Rd;
  logic [15:0] imm16;
  logic [31:0] busA, busB;
  logic        ExtOp, ALUSrc, RegDst, R_type, MemWr, Branch, MemtoReg, RegWr;
  logic [2:0]  ALUop;
  logic [5:0]  func;
  logic        stall;
  logic [31:0] alu_result, store_data, branch_target;
  logic [4:0]  dest_reg;
  logic        MemWr_out, MemtoReg_out, RegWr_out, branch_taken;

  ex_stage dut (
    .clk(clk), .rst(rst), .PC(PC), .Rt(Rt), .Rd(Rd), .imm16(imm16),
    .busA(busA), .busB(busB), .ExtOp(ExtOp), .ALUSrc(ALUSrc), .RegDst(RegDst),
    .R_type(R_type), .MemWr(MemWr), .Branch(Branch), .MemtoReg(MemtoReg),
    .RegWr(RegWr), .ALUop(ALUop), .func(func), .stall(stall),
    .alu_result(alu_result), .store_data(store_data), .branch_target(branch_target),
    .dest_reg(dest_reg), .MemWr_out(MemWr_out), .MemtoReg_out(MemtoReg_out),
    .RegWr_out(RegWr_out), .branch_taken(branch_taken)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] hi_m = 32'h0;
  logic [31:0] lo_m = 32'h0;
  logic [5:0]  funcs [12] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A,
                              6'h2B, 6'h19, 6'h1B, 6'h10, 6'h12, 6'h3F};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_nop();
    PC = 0; Rt = 0; Rd = 0; imm16 = 0; busA = 0; busB = 0;
    ExtOp = 0; ALUSrc = 0; RegDst = 0; R_type = 0; MemWr = 0; Branch = 0;
    MemtoReg = 0; RegWr = 0; ALUop = 0; func = 0;
  endtask

  function automatic logic is_md();
    return R_type && (func == 6'h19 || func == 6'h1B);
  endfunction

  function automatic logic [31:0] ref_result();
    logic [31:0] imm32, b;
    imm32 = ExtOp ? 32'($signed(imm16)) : {16'h0, imm16};
    b = ALUSrc ? imm32 : busB;
    if (!R_type) begin
      case (ALUop)
        3'd0: return busA + b;
        3'd1: return busA - b;
        3'd2: return busA & b;
        3'd3: return busA | b;
        3'd4: return ($signed(busA) < $signed(b)) ? 32'd1 : 32'd0;
        3'd5: return (busA < b) ? 32'd1 : 32'd0;
        3'd6: return {imm16, 16'h0};
        default: return busA ^ b;
      endcase
    end
    case (func)
      6'h20: return busA + b;
      6'h22: return busA - b;
      6'h24: return busA & b;
      6'h25: return busA | b;
      6'h26: return busA ^ b;
      6'h2A: return ($signed(busA) < $signed(b)) ? 32'd1 : 32'd0;
      6'h2B: return (busA < b) ? 32'd1 : 32'd0;
      6'h10: return hi_m;
      6'h12: return lo_m;
      default: return 32'h0;
    endcase
  endfunction

  task automatic run_single();
    logic [31:0] e_res, e_tgt;
    logic [4:0]  e_dst;
    logic        e_bt;
    e_res = ref_result();
    e_tgt = PC + 32'($signed(imm16)) * 4;
    e_dst = RegDst ? Rd : Rt;
    e_bt  = Branch && (busA == busB);
    #1;
    check("stall_single", stall, 0);
    @(posedge clk); #1;
    check("alu_result", alu_result, e_res);
    check("store_data", store_data, busB);
    check("branch_target", branch_target, e_tgt);
    check("dest_reg", dest_reg, e_dst);
    check("MemWr_out", MemWr_out, MemWr);
    check("MemtoReg_out", MemtoReg_out, MemtoReg);
    check("RegWr_out", RegWr_out, RegWr);
    check("branch_taken", branch_taken, e_bt);
  endtask

  task automatic run_md();
    int   n;
    logic bubble_bad;
    logic [63:0] prod;
    n = 0;
    bubble_bad = 0;
    #1;
    check("md_start_stall", stall, 1);
    while (stall && n < 40) begin
      n++;
      @(posedge clk); #1;
      if (RegWr_out || MemWr_out || MemtoReg_out || branch_taken) bubble_bad = 1;
    end
    check("md_stall_cycles", n, 32);
    check("md_stall_bubbles", bubble_bad, 0);
    @(posedge clk); #1;
    check("md_retire_regwr", RegWr_out, 0);
    check("md_retire_memwr", MemWr_out, 0);
    if (func == 6'h19) begin
      prod = 64'(busA) * 64'(busB);
      hi_m = prod[63:32];
      lo_m = prod[31:0];
    end else if (busB == 0) begin
      hi_m = busA;
      lo_m = 32'hFFFF_FFFF;
    end else begin
      hi_m = busA % busB;
      lo_m = busA / busB;
    end
  endtask

  task automatic exec();
    if (is_md()) run_md();
    else run_single();
  endtask

  task automatic do_r(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    set_nop();
    R_type = 1; func = f; busA = a; busB = b; RegDst = 1; RegWr = 1; Rd = 5'd9;
    exec();
  endtask

  initial begin
    set_nop();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_alu_result", alu_result, 0);
    check("rst_branch_target", branch_target, 0);
    check("rst_dest_reg", dest_reg, 0);
    check("rst_controls", {MemWr_out, MemtoReg_out, RegWr_out, branch_taken}, 0);
    rst = 0;
    #1;
    check("rst_stall", stall, 0);

    // ADDI with a sign-extended -1
    set_nop();
    busA = 5; imm16 = 16'hFFFF; ExtOp = 1; ALUSrc = 1; ALUop = 3'b000;
    RegWr = 1; RegDst = 0; Rt = 5'd3;
    exec();
    check("addi_result", alu_result, 4);
    check("addi_dest", dest_reg, 3);
    check("addi_regwr", RegWr_out, 1);

    // Backward taken branch
    set_nop();
    PC = 32'h100; imm16 = 16'hFFFE; busA = 7; busB = 7; Branch = 1;
    exec();
    check("br_taken", branch_taken, 1);
    check("br_target", branch_target, 32'h0F8);

    // MULTU then MFHI / MFLO right after retirement
    do_r(6'h19, 32'hFFFF_FFFF, 32'd2);
    do_r(6'h10, 0, 0);
    check("multu_hi", alu_result, 32'h1);
    do_r(6'h12, 0, 0);
    check("multu_lo", alu_result, 32'hFFFF_FFFE);

    // DIVU by zero
    do_r(6'h1B, 32'd100, 32'd0);
    do_r(6'h10, 0, 0);
    check("divz_hi", alu_result, 32'd100);
    do_r(6'h12, 0, 0);
    check("divz_lo", alu_result, 32'hFFFF_FFFF);

    // Signed vs unsigned compare
    do_r(6'h2A, 32'hFFFF_FFFF, 32'd1);
    check("slt_result", alu_result, 1);
    do_r(6'h2B, 32'hFFFF_FFFF, 32'd1);
    check("sltu_result", alu_result, 0);

    // Reset in the middle of a multiply
    set_nop();
    R_type = 1; func = 6'h19; busA = 32'h1234_5678; busB = 32'h9ABC_DEF0;
    #1;
    check("rstmd_start", stall, 1);
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    set_nop();
    #1;
    check("rstmd_stall", stall, 0);
    check("rstmd_outputs", {alu_result, store_data, branch_target, dest_reg,
                            MemWr_out, MemtoReg_out, RegWr_out, branch_taken}, 0);
    hi_m = 0;
    lo_m = 0;
    do_r(6'h10, 0, 0);
    check("rstmd_hi", alu_result, 0);
    do_r(6'h12, 0, 0);
    check("rstmd_lo", alu_result, 0);

    // Randomized mix
    for (int i = 0; i < 300; i++) begin
      PC       = $urandom;
      Rt       = 5'($urandom);
      Rd       = 5'($urandom);
      imm16    = 16'($urandom);
      busA     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      busB     = ($urandom_range(0, 3) == 0) ? busA : $urandom;
      ExtOp    = 1'($urandom);
      RegDst   = 1'($urandom);
      MemWr    = 1'($urandom);
      Branch   = 1'($urandom);
      MemtoReg = 1'($urandom);
      RegWr    = 1'($urandom);
      ALUop    = 3'($urandom);
      R_type   = 1'($urandom);
      ALUSrc   = R_type ? 1'b0 : 1'($urandom);
      func     = funcs[$urandom_range(0, 11)];
      if (is_md() && $urandom_range(0, 3) != 0) func = 6'h20;
      if (func == 6'h1B && $urandom_range(0, 3) == 0) busB = 0;
      exec();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
